// File: rtl/apb_master_mc.sv
// Multi-completer APB master: takes local transfer commands and drives them onto
// NUM_SLAVES APB completers, decoded by address region. Define APB_TIMEOUT_EN to enable the ACCESS-phase timeout.
module apb_master_mc #(
  parameter int ADDRESS    = 8,
  parameter int DATA       = 8,
  parameter int LOCATION   = 64,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       transfer,
  input  logic                       READ_WRITE,
  input  logic [ADDRESS-1:0]         cmd_addr,
  input  logic [DATA-1:0]            cmd_wdata,
  output logic                       cmd_ready,
  output logic                       rsp_valid,
  output logic [DATA-1:0]            rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDRESS-1:0]         PADDR,
  output logic [DATA-1:0]            PWDATA,
  output logic                       PWRITE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  input  logic [NUM_SLAVES*DATA-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY,
  input  logic [NUM_SLAVES-1:0]      PSLVERR
);
  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]   idx, cmd_idx;
  logic [31:0]     region;
  logic            decode_ok, accept, sel_ready, sel_err, abort;
  logic [DATA-1:0] sel_rdata;
  logic            dec_pend;

  assign region    = 32'(cmd_addr) / 32'(LOCATION);
  assign decode_ok = region < 32'(NUM_SLAVES);
  assign cmd_idx   = region[IW-1:0];
  assign sel_ready = PREADY[idx];
  assign sel_err   = PSLVERR[idx];
  assign sel_rdata = PRDATA[idx*DATA +: DATA];
  assign accept    = transfer && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                         wait_cnt <= '0;
    else if (state == SETUP)            wait_cnt <= '0;
    else if (state == ACCESS && !sel_ready) wait_cnt <= wait_cnt + CW'(1);
  end

  // Abort on the wait cycle whose increment would bring the count to TIMEOUT.
  assign abort = (state == ACCESS) && !sel_ready && (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        // A decode error taken in the completion cycle still owes its response.
        cmd_ready = !dec_pend;
        if (transfer && !dec_pend && decode_ok) state_nxt = SETUP;
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (abort) state_nxt = IDLE;
        else if (sel_ready) begin
          cmd_ready = 1'b1;
          state_nxt = (transfer && decode_ok) ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PSEL = '0;
    if (state != IDLE) PSEL[idx] = 1'b1;
  end
  assign PENABLE = (state == ACCESS);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      idx       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      dec_pend  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      dec_pend  <= 1'b0;
      if (accept) begin
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
        PWRITE <= READ_WRITE;
        if (decode_ok) idx <= cmd_idx;
      end
      if (state == IDLE && (dec_pend || (accept && !decode_ok))) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
      if (state == ACCESS && sel_ready) begin
        rsp_valid <= 1'b1;
        rsp_err   <= sel_err;
        rsp_rdata <= (PWRITE || sel_err) ? '0 : sel_rdata;
        if (accept && !decode_ok) dec_pend <= 1'b1;
      end
      if (abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_mc.sv
// Self-checking bench for apb_master_mc: expected responses are queued at accept
// time and compared (data, error, arrival cycle) against responses captured from the DUT.
module tb_apb_master_mc;
  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer, READ_WRITE;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_err, PWRITE, PENABLE;
  logic [7:0]  rsp_rdata, PADDR, PWDATA;
  logic [3:0]  PSEL, PREADY, PSLVERR;
  logic [31:0] PRDATA;

  logic        d2_transfer, d2_cmd_ready, d2_rsp_valid, d2_rsp_err, d2_pwrite, d2_penable;
  logic [7:0]  d2_rsp_rdata, d2_paddr, d2_pwdata;
  logic [1:0]  d2_psel, d2_pready, d2_pslverr;
  logic [15:0] d2_prdata;

  typedef struct packed {logic [7:0] rdata; logic err; logic [31:0] cyc;} rsp_t;
  rsp_t exp_q[$], got_q[$];
  int cyc = 0;
  int nvec = 0;
  int errs = 0;

  apb_master_mc dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  apb_master_mc #(.NUM_SLAVES(2)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(d2_transfer), .READ_WRITE(READ_WRITE),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ready(d2_cmd_ready),
    .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata), .rsp_err(d2_rsp_err),
    .PADDR(d2_paddr), .PWDATA(d2_pwdata), .PWRITE(d2_pwrite), .PSEL(d2_psel), .PENABLE(d2_penable),
    .PRDATA(d2_prdata), .PREADY(d2_pready), .PSLVERR(d2_pslverr));

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) if (rsp_valid === 1'b1) got_q.push_back({rsp_rdata, rsp_err, 32'(cyc)});

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) tick();
    nvec++; if ({PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      errs++; $display("FAIL reset_outputs got psel=%b en=%b addr=%h wd=%h rv=%b", PSEL, PENABLE, PADDR, PWDATA, rsp_valid); end
    PRESET = 1'b0;
    tick();
    transfer = 1'b1; READ_WRITE = 1'b1; cmd_addr = 8'h02; cmd_wdata = 8'h06; PREADY = '0;
    tick();
    transfer = 1'b0;
    repeat (2) tick();
    nvec++; if ({PSEL, PENABLE} !== 5'b00011) begin
      errs++; $display("FAIL reset_pre_access got psel=%b en=%b exp psel=0001 en=1", PSEL, PENABLE); end
    PRESET = 1'b1; #1;
    nvec++; if ({PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      errs++; $display("FAIL reset_mid_access got psel=%b en=%b addr=%h wd=%h w=%b", PSEL, PENABLE, PADDR, PWDATA, PWRITE); end
    tick();
    PRESET = 1'b0;
    tick();
    nvec++; if ({cmd_ready, PSEL, PENABLE} !== 6'b100000) begin
      errs++; $display("FAIL reset_idle got rdy=%b psel=%b en=%b exp rdy=1 psel=0 en=0", cmd_ready, PSEL, PENABLE); end
    PREADY = '1;
    repeat (4) tick();
    PREADY = '0;
    nvec++; if (got_q.size() != 0) begin
      errs++; $display("FAIL reset_no_rsp got %0d responses exp 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_write();
    int acc;
    PREADY = 4'b0010; PSLVERR = 4'b1101;
    transfer = 1'b1; READ_WRITE = 1'b1; cmd_addr = 8'h42; cmd_wdata = 8'h62;
    nvec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_ready got %b exp 1", cmd_ready); end
    acc = cyc; exp_q.push_back({8'h00, 1'b0, 32'(acc + 3)});
    tick();
    transfer = 1'b0;
    nvec++; if ({PSEL, PENABLE, cmd_ready} !== 6'b001000) begin
      errs++; $display("FAIL wr_setup got psel=%b en=%b rdy=%b exp 0010/0/0", PSEL, PENABLE, cmd_ready); end
    nvec++; if ({PADDR, PWDATA, PWRITE} !== {8'h42, 8'h62, 1'b1}) begin
      errs++; $display("FAIL wr_bus got addr=%h wd=%h w=%b exp 42/62/1", PADDR, PWDATA, PWRITE); end
    tick();
    nvec++; if ({PSEL, PENABLE} !== 5'b00101) begin
      errs++; $display("FAIL wr_access got psel=%b en=%b exp 0010/1", PSEL, PENABLE); end
    tick();
    nvec++; if ({PSEL, PENABLE} !== 5'b00000) begin
      errs++; $display("FAIL wr_idle got psel=%b en=%b exp 0/0", PSEL, PENABLE); end
    PREADY = '0; PSLVERR = '0;
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    nvec++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL wr_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      rsp_t e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      nvec++; if (g !== e) begin errs++;
        $display("FAIL wr_rsp got d=%h e=%b c=%0d exp d=%h e=%b c=%0d", g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_read_wait();
    int acc;
    PREADY = 4'b1110; PRDATA = 32'hDDCCBB55;
    transfer = 1'b1; READ_WRITE = 1'b0; cmd_addr = 8'h0F;
    acc = cyc; exp_q.push_back({8'h03, 1'b0, 32'(acc + 6)});
    tick();
    transfer = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      if (w == 3) begin PREADY = 4'b0001; PRDATA[7:0] = 8'h03; end
      nvec++; if ({PSEL, PENABLE, PADDR, PWRITE} !== {4'b0001, 1'b1, 8'h0F, 1'b0}) begin
        errs++; $display("FAIL rd_wait%0d got psel=%b en=%b addr=%h exp 0001/1/0f", w, PSEL, PENABLE, PADDR); end
      tick();
    end
    nvec++; if (PENABLE !== 1'b0) begin errs++; $display("FAIL rd_enable_drop got %b exp 0", PENABLE); end
    PREADY = '0;
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    nvec++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL rd_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      rsp_t e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      nvec++; if (g !== e) begin errs++;
        $display("FAIL rd_rsp got d=%h e=%b c=%0d exp d=%h e=%b c=%0d", g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [3];
    int acc0;
    addrs = '{8'h10, 8'h50, 8'h90};
    PREADY = '1; PSLVERR = '0; READ_WRITE = 1'b1; acc0 = 0;
    for (int i = 0; i < 3; i++) begin
      transfer = 1'b1; cmd_addr = addrs[i]; cmd_wdata = 8'hA0 + 8'(i);
      for (int k = 0; k < 8 && !cmd_ready; k++) begin
        nvec++; if (PSEL === 4'b0000) begin errs++; $display("FAIL b2b_gap%0d got psel=0 exp nonzero", i); end
        tick();
      end
      nvec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready%0d got %b exp 1", i, cmd_ready); end
      if (i == 0) acc0 = cyc;
      else begin
        nvec++; if (cyc != acc0 + 2 * i) begin
          errs++; $display("FAIL b2b_accept%0d got cycle %0d exp %0d", i, cyc, acc0 + 2 * i); end
      end
      exp_q.push_back({8'h00, 1'b0, 32'(cyc + 3)});
      tick();
    end
    transfer = 1'b0;
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    nvec++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL b2b_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      rsp_t e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      nvec++; if (g !== e) begin errs++;
        $display("FAIL b2b_rsp got d=%h e=%b c=%0d exp d=%h e=%b c=%0d", g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc); end
    end
    got_q.delete(); exp_q.delete();
    PREADY = '0;
  endtask

  task automatic test_errors();
    int acc;
    PREADY = 4'b0100; PSLVERR = 4'b0100; PRDATA = 32'h11AA2233;
    transfer = 1'b1; READ_WRITE = 1'b0; cmd_addr = 8'h85;
    acc = cyc; exp_q.push_back({8'h00, 1'b1, 32'(acc + 3)});
    tick();
    transfer = 1'b0;
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    nvec++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL slverr_rsp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      rsp_t e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      nvec++; if (g !== e) begin errs++;
        $display("FAIL slverr_rsp got d=%h e=%b c=%0d exp d=%h e=%b c=%0d", g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc); end
    end
    got_q.delete(); exp_q.delete();
    PREADY = '0; PSLVERR = '0;
    // decode error on the two-completer instance
    d2_transfer = 1'b1; READ_WRITE = 1'b1; cmd_addr = 8'hC0; cmd_wdata = 8'h5A;
    nvec++; if (d2_cmd_ready !== 1'b1) begin errs++; $display("FAIL dec_ready got %b exp 1", d2_cmd_ready); end
    tick();
    d2_transfer = 1'b0;
    nvec++; if ({d2_psel, d2_rsp_valid, d2_rsp_err, d2_rsp_rdata} !== {2'b00, 1'b1, 1'b1, 8'h00}) begin
      errs++; $display("FAIL dec_rsp got psel=%b v=%b e=%b d=%h exp 00/1/1/00", d2_psel, d2_rsp_valid, d2_rsp_err, d2_rsp_rdata); end
    tick();
    nvec++; if ({d2_psel, d2_rsp_valid, d2_cmd_ready} !== 4'b0001) begin
      errs++; $display("FAIL dec_after got psel=%b v=%b rdy=%b exp 00/0/1", d2_psel, d2_rsp_valid, d2_cmd_ready); end
  endtask

  task automatic test_long_wait();
    int acc;
    PREADY = '0;
    transfer = 1'b1; READ_WRITE = 1'b1; cmd_addr = 8'hC1; cmd_wdata = 8'h77;
    acc = cyc;
    tick();
    transfer = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    exp_q.push_back({8'h00, 1'b1, 32'(acc + 18)});
    repeat (16) begin
      nvec++; if ({PSEL, PENABLE} !== 5'b10001) begin
        errs++; $display("FAIL to_access got psel=%b en=%b exp 1000/1", PSEL, PENABLE); end
      tick();
    end
    nvec++; if ({PSEL, PENABLE} !== 5'b00000) begin
      errs++; $display("FAIL to_abort got psel=%b en=%b exp 0/0", PSEL, PENABLE); end
    PREADY = 4'b1000;
    tick();
    PREADY = '0;
`else
    repeat (40) begin
      nvec++; if ({PSEL, PENABLE} !== 5'b10001) begin
        errs++; $display("FAIL wait_access got psel=%b en=%b exp 1000/1", PSEL, PENABLE); end
      tick();
    end
    nvec++; if (got_q.size() != 0) begin errs++; $display("FAIL wait_early_rsp got %0d exp 0", got_q.size()); end
    PREADY = 4'b1000;
    exp_q.push_back({8'h00, 1'b0, 32'(cyc + 1)});
    tick();
    PREADY = '0;
`endif
    for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
    repeat (3) tick();
    nvec++; if (got_q.size() != exp_q.size()) begin
      errs++; $display("FAIL wait_rsp_count got %0d exp %0d (accepted cycle %0d)", got_q.size(), exp_q.size(), acc); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      rsp_t e, g; e = exp_q.pop_front(); g = got_q.pop_front();
      nvec++; if (g !== e) begin errs++;
        $display("FAIL wait_rsp got d=%h e=%b c=%0d exp d=%h e=%b c=%0d", g.rdata, g.err, g.cyc, e.rdata, e.err, e.cyc); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    PRESET = 1'b1; transfer = 1'b0; d2_transfer = 1'b0; READ_WRITE = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    d2_prdata = 16'h1234; d2_pready = '1; d2_pslverr = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_errors();
    test_long_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
